tx_frame_scheduler: RTL and testbench

- Arbitrates PICC->PCD response frames between two byte-stream requesters and sequences them into the tx module.
- Requester 0 is the ISO14443-3 initialisation/anticollision logic and has fixed priority. Requester 1 is the application (14443-4) layer.
- Buffers bytes in a small FIFO and drives tx data/data_bits/ready_to_send, answering the tx req pulses.
- Aborts a frame on a new PCD frame (rx_soc). Sits between the protocol layers and tx; fdt_trigger timing remains inside tx.

---
 rtl/tx_frame_scheduler.sv | 233 +++++++++++++++++++++++
 tb/tb_tx_frame_scheduler.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_frame_scheduler.sv
// Two-requester response-frame scheduler in front of the tx byte serialiser.
// Requester 0 has fixed priority; bytes are staged in a small FIFO and handed out on tx_req.
module tx_frame_scheduler #(
   parameter int FIFO_DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req0_valid,
   input  logic [7:0] req0_data,
   input  logic [2:0] req0_data_bits,
   input  logic       req0_last,
   output logic       req0_ready,
   input  logic       req1_valid,
   input  logic [7:0] req1_data,
   input  logic [2:0] req1_data_bits,
   input  logic       req1_last,
   output logic       req1_ready,
   input  logic       rx_soc,
   output logic [7:0] tx_data,
   output logic [2:0] tx_data_bits,
   output logic       tx_ready_to_send,
   input  logic       tx_req,
   output logic [1:0] grant,
   output logic       done,
   output logic       aborted,
   output logic       underrun,
   output logic [1:0] o_dbg_state
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] DEPTH_CNT = (AW+1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACTIVE = 2'd1,
      S_FLUSH  = 2'd2
   } state_t;

   state_t          r_state;
   logic [1:0]      r_grant;
   logic            r_started;
   logic            r_last_acc;
   logic            r_rts;
   logic [7:0]      r_tx_data;
   logic [2:0]      r_tx_bits;
   logic            r_done;
   logic            r_aborted;
   logic            r_underrun;
   logic [AW-1:0]   r_wr_ptr;
   logic [AW-1:0]   r_rd_ptr;
   logic [AW:0]     r_count;
   logic [10:0]     r_mem [FIFO_DEPTH];

   state_t          w_state_nx;
   logic [1:0]      w_grant_nx;
   logic            w_started_nx;
   logic            w_last_acc_nx;
   logic            w_rts_nx;
   logic            w_done_nx;
   logic            w_aborted_nx;
   logic            w_underrun_nx;
   logic            w_push;
   logic            w_pop;
   logic            w_clear;

   logic            w_full;
   logic            w_empty;
   logic            w_rdy_active;
   logic            w_flush;
   logic            w_accept;
   logic            w_accept_last;
   logic [7:0]      w_sel_data;
   logic [2:0]      w_sel_bits;
   logic            w_sel_last;
   logic [2:0]      w_push_bits;

   assign w_full       = (r_count == DEPTH_CNT);
   assign w_empty      = (r_count == '0);
   assign w_rdy_active = (r_state == S_ACTIVE) && !w_full && !r_last_acc;
   assign w_flush      = (r_state == S_FLUSH);

   // Ready never depends on valid, so the requester may sample it before driving.
   assign req0_ready = r_grant[0] && (w_rdy_active || w_flush);
   assign req1_ready = r_grant[1] && (w_rdy_active || w_flush);

   assign w_sel_data    = r_grant[1] ? req1_data      : req0_data;
   assign w_sel_bits    = r_grant[1] ? req1_data_bits : req0_data_bits;
   assign w_sel_last    = r_grant[1] ? req1_last      : req0_last;
   assign w_accept      = (req0_valid && req0_ready) || (req1_valid && req1_ready);
   assign w_accept_last = w_accept && w_sel_last;
   assign w_push_bits   = w_sel_last ? w_sel_bits : 3'd0;

   always_comb begin
      w_state_nx    = r_state;
      w_grant_nx    = r_grant;
      w_started_nx  = r_started;
      w_last_acc_nx = r_last_acc;
      w_rts_nx      = r_rts;
      w_done_nx     = 1'b0;
      w_aborted_nx  = 1'b0;
      w_underrun_nx = 1'b0;
      w_push        = 1'b0;
      w_pop         = 1'b0;
      w_clear       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (req0_valid) begin
               w_grant_nx = 2'b01;
               w_state_nx = S_ACTIVE;
            end else if (req1_valid) begin
               w_grant_nx = 2'b10;
               w_state_nx = S_ACTIVE;
            end
         end
         S_ACTIVE: begin
            if (rx_soc) begin
               // A byte caught in the abort cycle is dropped along with the buffered ones.
               w_clear       = 1'b1;
               w_rts_nx      = 1'b0;
               w_aborted_nx  = 1'b1;
               w_started_nx  = 1'b0;
               w_last_acc_nx = 1'b0;
               if (r_last_acc || w_accept_last) begin
                  w_grant_nx = 2'b00;
                  w_state_nx = S_IDLE;
               end else begin
                  w_state_nx = S_FLUSH;
               end
            end else begin
               w_push = w_accept;
               if (w_accept_last) w_last_acc_nx = 1'b1;
               if (!r_started) begin
                  if (!w_empty && !r_rts) begin
                     w_pop        = 1'b1;
                     w_rts_nx     = 1'b1;
                     w_started_nx = 1'b1;
                  end
               end else if (tx_req) begin
                  if (!w_empty) begin
                     w_pop = 1'b1;
                  end else if (r_last_acc) begin
                     w_rts_nx      = 1'b0;
                     w_done_nx     = 1'b1;
                     w_grant_nx    = 2'b00;
                     w_started_nx  = 1'b0;
                     w_last_acc_nx = 1'b0;
                     w_state_nx    = S_IDLE;
                  end else begin
                     // Frame is broken; a same-cycle push is discarded, and if it was the last byte there is nothing left to flush.
                     w_rts_nx      = 1'b0;
                     w_underrun_nx = 1'b1;
                     w_started_nx  = 1'b0;
                     w_clear       = 1'b1;
                     w_last_acc_nx = 1'b0;
                     if (w_accept_last) begin
                        w_grant_nx = 2'b00;
                        w_state_nx = S_IDLE;
                     end else begin
                        w_state_nx = S_FLUSH;
                     end
                  end
               end
            end
         end
         S_FLUSH: begin
            if (w_accept_last) begin
               w_grant_nx    = 2'b00;
               w_started_nx  = 1'b0;
               w_last_acc_nx = 1'b0;
               w_state_nx    = S_IDLE;
            end
         end
         default: begin
            w_state_nx = S_IDLE;
            w_grant_nx = 2'b00;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_grant    <= 2'b00;
         r_started  <= 1'b0;
         r_last_acc <= 1'b0;
         r_rts      <= 1'b0;
         r_tx_data  <= 8'h00;
         r_tx_bits  <= 3'd0;
         r_done     <= 1'b0;
         r_aborted  <= 1'b0;
         r_underrun <= 1'b0;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
      end else begin
         r_state    <= w_state_nx;
         r_grant    <= w_grant_nx;
         r_started  <= w_started_nx;
         r_last_acc <= w_last_acc_nx;
         r_rts      <= w_rts_nx;
         r_done     <= w_done_nx;
         r_aborted  <= w_aborted_nx;
         r_underrun <= w_underrun_nx;
         if (w_pop) begin
            r_tx_data <= r_mem[r_rd_ptr][7:0];
            r_tx_bits <= r_mem[r_rd_ptr][10:8];
         end
         if (w_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
         end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_push && !w_clear) r_mem[r_wr_ptr] <= {w_push_bits, w_sel_data};
   end

   assign tx_data          = r_tx_data;
   assign tx_data_bits     = r_tx_bits;
   assign tx_ready_to_send = r_rts;
   assign grant            = r_grant;
   assign done             = r_done;
   assign aborted          = r_aborted;
   assign underrun         = r_underrun;
   assign o_dbg_state      = r_state;

endmodule

// File: tb/tb_tx_frame_scheduler.sv
// Bench for tx_frame_scheduler: a cycle table for single frames and arbitration,
// then hand-written sequences for backpressure, underrun, abort and async reset.
module tb_tx_frame_scheduler;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_FLUSH  = 2'd2;
   localparam logic [12:0] R_NONE   = 13'h0;

   logic       clk;
   logic       rst_n;
   logic       req0_valid, req0_last, req0_ready;
   logic [7:0] req0_data;
   logic [2:0] req0_data_bits;
   logic       req1_valid, req1_last, req1_ready;
   logic [7:0] req1_data;
   logic [2:0] req1_data_bits;
   logic       rx_soc;
   logic [7:0] tx_data;
   logic [2:0] tx_data_bits;
   logic       tx_ready_to_send;
   logic       tx_req;
   logic [1:0] grant;
   logic       done, aborted, underrun;
   logic [1:0] o_dbg_state;

   tx_frame_scheduler #(.FIFO_DEPTH(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_data(req0_data), .req0_data_bits(req0_data_bits),
      .req0_last(req0_last), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_data(req1_data), .req1_data_bits(req1_data_bits),
      .req1_last(req1_last), .req1_ready(req1_ready),
      .rx_soc(rx_soc), .tx_data(tx_data), .tx_data_bits(tx_data_bits),
      .tx_ready_to_send(tx_ready_to_send), .tx_req(tx_req), .grant(grant),
      .done(done), .aborted(aborted), .underrun(underrun), .o_dbg_state(o_dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

   int n_pass  = 0;
   int n_total = 0;
   int n_underrun = 0;
   logic [10:0] exp_q[$];

   always @(negedge clk) if (underrun === 1'b1) n_underrun++;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, want %h", nm, act, exp);
   endtask

   function automatic logic [18:0] out_vec();
      return {req0_ready, req1_ready, tx_ready_to_send, tx_data, tx_data_bits,
              grant, done, aborted, underrun};
   endfunction

   task automatic clear_inputs();
      {req0_valid, req0_data, req0_data_bits, req0_last} = R_NONE;
      {req1_valid, req1_data, req1_data_bits, req1_last} = R_NONE;
      rx_soc = 1'b0;
      tx_req = 1'b0;
   endtask

   task automatic do_reset(input string nm);
      clear_inputs();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check({nm, "_outs"}, 32'(out_vec()), 32'h0);
      check({nm, "_state"}, 32'(o_dbg_state), 32'(ST_IDLE));
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   // ---------------- driver tasks ----------------
   task automatic set_req(input int which, input logic v, input logic [7:0] d,
                          input logic [2:0] b, input logic l);
      if (which == 0) {req0_valid, req0_data, req0_data_bits, req0_last} = {v, d, b, l};
      else            {req1_valid, req1_data, req1_data_bits, req1_last} = {v, d, b, l};
   endtask

   function automatic logic cur_ready(input int which);
      return (which == 0) ? req0_ready : req1_ready;
   endfunction

   // Called at a negedge; returns at the negedge after the accepting posedge.
   task automatic send_byte(input int which, input logic [7:0] d, input logic [2:0] b,
                            input logic l, output int stalls);
      bit ok;
      ok = 1'b0;
      stalls = 0;
      set_req(which, 1'b1, d, b, l);
      for (int k = 0; k < 1000 && !ok; k++) begin
         if (cur_ready(which) === 1'b1) ok = 1'b1;
         else stalls++;
         @(negedge clk);
      end
      if (!ok) begin
         n_total++;
         $display("FAIL send_timeout: req%0d byte %h ready stayed 0, want 1", which, d);
      end
   endtask

   task automatic pulse_tx();
      tx_req = 1'b1;
      @(negedge clk);
      tx_req = 1'b0;
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      string       name;
      logic [12:0] r0;   // {valid, data, data_bits, last}
      logic [12:0] r1;
      logic        rx;
      logic        txr;
      logic [18:0] exp;  // {r0_rdy, r1_rdy, rts, data, bits, grant, done, aborted, underrun}
   } vec_t;

   vec_t vecs[$];

   task automatic add_vec(input string nm, input logic [12:0] r0, input logic [12:0] r1,
                          input logic rx, input logic txr, input logic [18:0] exp);
      vec_t v;
      v.name = nm; v.r0 = r0; v.r1 = r1; v.rx = rx; v.txr = txr; v.exp = exp;
      vecs.push_back(v);
   endtask

   initial begin
      int st;
      int stall_a[10];
      int und_before;
      logic [10:0] e;

      rst_n = 1'b0;
      clear_inputs();

      // Single frame on req1: A5, 3C, 0F.
      add_vec("t1_arb",      R_NONE, {1'b1,8'hA5,3'd0,1'b0}, 0, 0, {1'b0,1'b1,1'b0,8'h00,3'd0,2'b10,3'b000});
      add_vec("t1_acc_a5",   R_NONE, {1'b1,8'hA5,3'd0,1'b0}, 0, 0, {1'b0,1'b1,1'b0,8'h00,3'd0,2'b10,3'b000});
      add_vec("t1_load_a5",  R_NONE, {1'b1,8'h3C,3'd0,1'b0}, 0, 0, {1'b0,1'b1,1'b1,8'hA5,3'd0,2'b10,3'b000});
      add_vec("t1_acc_last", R_NONE, {1'b1,8'h0F,3'd0,1'b1}, 0, 0, {1'b0,1'b0,1'b1,8'hA5,3'd0,2'b10,3'b000});
      add_vec("t1_req_3c",   R_NONE, R_NONE, 0, 1, {1'b0,1'b0,1'b1,8'h3C,3'd0,2'b10,3'b000});
      add_vec("t1_gap",      R_NONE, R_NONE, 0, 0, {1'b0,1'b0,1'b1,8'h3C,3'd0,2'b10,3'b000});
      add_vec("t1_req_0f",   R_NONE, R_NONE, 0, 1, {1'b0,1'b0,1'b1,8'h0F,3'd0,2'b10,3'b000});
      add_vec("t1_done",     R_NONE, R_NONE, 0, 1, {1'b0,1'b0,1'b0,8'h0F,3'd0,2'b00,3'b100});
      add_vec("t1_idle",     R_NONE, R_NONE, 0, 0, {1'b0,1'b0,1'b0,8'h0F,3'd0,2'b00,3'b000});
      // Both requesters valid together: req0 wins, req1 follows.
      add_vec("t2_arb",   {1'b1,8'h11,3'd0,1'b1}, {1'b1,8'h22,3'd7,1'b1}, 0, 0, {1'b1,1'b0,1'b0,8'h0F,3'd0,2'b01,3'b000});
      add_vec("t2_acc0",  {1'b1,8'h11,3'd0,1'b1}, {1'b1,8'h22,3'd7,1'b1}, 0, 0, {1'b0,1'b0,1'b0,8'h0F,3'd0,2'b01,3'b000});
      add_vec("t2_load0", R_NONE, {1'b1,8'h22,3'd7,1'b1}, 0, 0, {1'b0,1'b0,1'b1,8'h11,3'd0,2'b01,3'b000});
      add_vec("t2_done0", R_NONE, {1'b1,8'h22,3'd7,1'b1}, 0, 1, {1'b0,1'b0,1'b0,8'h11,3'd0,2'b00,3'b100});
      add_vec("t2_arb1",  R_NONE, {1'b1,8'h22,3'd7,1'b1}, 0, 0, {1'b0,1'b1,1'b0,8'h11,3'd0,2'b10,3'b000});
      add_vec("t2_acc1",  R_NONE, {1'b1,8'h22,3'd7,1'b1}, 0, 0, {1'b0,1'b0,1'b0,8'h11,3'd0,2'b10,3'b000});
      add_vec("t2_load1", R_NONE, R_NONE, 0, 0, {1'b0,1'b0,1'b1,8'h22,3'd7,2'b10,3'b000});
      add_vec("t2_done1", R_NONE, R_NONE, 0, 1, {1'b0,1'b0,1'b0,8'h22,3'd7,2'b00,3'b100});
      // Partial last byte on req0; data_bits of a non-last byte is forced to 0.
      add_vec("t3_arb",    {1'b1,8'h93,3'd5,1'b0}, R_NONE, 0, 0, {1'b1,1'b0,1'b0,8'h22,3'd7,2'b01,3'b000});
      add_vec("t3_acc93",  {1'b1,8'h93,3'd5,1'b0}, R_NONE, 0, 0, {1'b1,1'b0,1'b0,8'h22,3'd7,2'b01,3'b000});
      add_vec("t3_load93", {1'b1,8'h20,3'd3,1'b1}, R_NONE, 0, 0, {1'b0,1'b0,1'b1,8'h93,3'd0,2'b01,3'b000});
      add_vec("t3_req20",  R_NONE, R_NONE, 0, 1, {1'b0,1'b0,1'b1,8'h20,3'd3,2'b01,3'b000});
      add_vec("t3_done",   R_NONE, R_NONE, 0, 1, {1'b0,1'b0,1'b0,8'h20,3'd3,2'b00,3'b100});
      add_vec("t3_soc_idle", R_NONE, R_NONE, 1, 0, {1'b0,1'b0,1'b0,8'h20,3'd3,2'b00,3'b000});
      add_vec("t3_req_idle", R_NONE, R_NONE, 0, 1, {1'b0,1'b0,1'b0,8'h20,3'd3,2'b00,3'b000});

      do_reset("rst0");
      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         {req0_valid, req0_data, req0_data_bits, req0_last} = vecs[i].r0;
         {req1_valid, req1_data, req1_data_bits, req1_last} = vecs[i].r1;
         rx_soc = vecs[i].rx;
         tx_req = vecs[i].txr;
         @(posedge clk);
         #1;
         check(vecs[i].name, 32'(out_vec()), 32'(vecs[i].exp));
      end
      @(negedge clk);
      clear_inputs();

      // ---- 10-byte frame against a slow tx: backpressure at FIFO full ----
      do_reset("rst_a");
      und_before = n_underrun;
      fork
         begin
            for (int i = 0; i < 10; i++) begin
               send_byte(0, 8'h40 + 8'(i), 3'd0, (i == 9), stall_a[i]);
               exp_q.push_back({3'd0, 8'h40 + 8'(i)});
            end
            set_req(0, 1'b0, 8'h00, 3'd0, 1'b0);
         end
         begin
            for (int i = 0; i < 10; i++) begin
               repeat (100) @(negedge clk);
               if (exp_q.size() == 0) check($sformatf("a_byte%0d_queued", i), 0, 1);
               else begin
                  e = exp_q.pop_front();
                  check($sformatf("a_byte%0d", i), {20'h0, tx_ready_to_send, tx_data_bits, tx_data},
                        {20'h0, 1'b1, e});
               end
               pulse_tx();
            end
            check("a_done", {30'h0, done, grant == 2'b00}, 32'h3);
         end
      join
      check("a_no_stall_1_4", stall_a[1] + stall_a[2] + stall_a[3] + stall_a[4], 0);
      check("a_full_stall_5", (stall_a[5] > 50) ? 1 : 0, 1);
      check("a_no_underrun", n_underrun - und_before, 0);

      // ---- requester stalls, tx underruns, remaining byte flushed ----
      do_reset("rst_b");
      send_byte(1, 8'h61, 3'd0, 1'b0, st);
      send_byte(1, 8'h62, 3'd0, 1'b0, st);
      set_req(1, 1'b0, 8'h00, 3'd0, 1'b0);
      check("b_first", {23'h0, tx_ready_to_send, tx_data}, {23'h0, 1'b1, 8'h61});
      pulse_tx();
      check("b_second", {23'h0, tx_ready_to_send, tx_data}, {23'h0, 1'b1, 8'h62});
      pulse_tx();
      check("b_underrun", {28'h0, underrun, tx_ready_to_send, o_dbg_state}, {28'h0, 1'b1, 1'b0, ST_FLUSH});
      @(negedge clk);
      check("b_underrun_pulse", 32'(underrun), 0);
      send_byte(1, 8'h63, 3'd0, 1'b1, st);
      set_req(1, 1'b0, 8'h00, 3'd0, 1'b0);
      check("b_flushed", {19'h0, grant, o_dbg_state, tx_ready_to_send, tx_data},
            {19'h0, 2'b00, ST_IDLE, 1'b0, 8'h62});

      // ---- rx_soc mid-frame with two bytes buffered ----
      do_reset("rst_c");
      send_byte(1, 8'h71, 3'd0, 1'b0, st);
      send_byte(1, 8'h72, 3'd0, 1'b0, st);
      send_byte(1, 8'h73, 3'd0, 1'b0, st);
      set_req(1, 1'b0, 8'h00, 3'd0, 1'b0);
      rx_soc = 1'b1;
      @(negedge clk);
      rx_soc = 1'b0;
      check("c_abort", {26'h0, aborted, tx_ready_to_send, req1_ready, grant[1], o_dbg_state},
            {26'h0, 1'b1, 1'b0, 1'b1, 1'b1, ST_FLUSH});
      @(negedge clk);
      check("c_abort_pulse", 32'(aborted), 0);
      send_byte(1, 8'h74, 3'd0, 1'b1, st);
      set_req(1, 1'b0, 8'h00, 3'd0, 1'b0);
      check("c_flush_idle", {28'h0, grant, o_dbg_state}, {28'h0, 2'b00, ST_IDLE});
      send_byte(0, 8'hC3, 3'd2, 1'b1, st);
      set_req(0, 1'b0, 8'h00, 3'd0, 1'b0);
      check("c_new_pending", 32'(tx_ready_to_send), 0);
      @(negedge clk);
      check("c_new_byte", {20'h0, tx_ready_to_send, tx_data_bits, tx_data}, {20'h0, 1'b1, 3'd2, 8'hC3});
      pulse_tx();
      check("c_new_done", {30'h0, done, grant == 2'b00}, 32'h3);

      // ---- asynchronous reset in the middle of a frame ----
      do_reset("rst_d");
      send_byte(1, 8'h81, 3'd0, 1'b0, st);
      send_byte(1, 8'h82, 3'd0, 1'b0, st);
      check("d_pending", 32'(tx_ready_to_send), 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("d_async_outs", 32'(out_vec()), 0);
      check("d_async_state", 32'(o_dbg_state), 32'(ST_IDLE));
      @(negedge clk);
      clear_inputs();
      rst_n = 1'b1;
      @(negedge clk);
      check("d_after_release", {13'h0, out_vec()}, 32'h0);

      // ---------------- report ----------------
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
